// File: rtl/sentinel_trace_mux_if.sv
// Trace record stream from the mux to the host DMA: show-ahead valid/ready with fixed-width record.
interface sentinel_trace_mux_if;
    logic         trace_valid;
    logic         trace_ready;
    logic [511:0] trace_data;
    logic [6:0]   trace_size;

    modport master (output trace_valid, output trace_data, output trace_size, input trace_ready);
    modport slave  (input trace_valid, input trace_data, input trace_size, output trace_ready);
endinterface

// File: rtl/sentinel_trace_mux.sv
// Timestamps, samples and round-robin merges N_CH attribution channels into one trace record FIFO.
// Event-to-trace_valid latency 2 cycles; a full FIFO stalls the holds and later events on busy channels drop.
module sentinel_trace_mux #(
    parameter int N_CH         = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int EMIT_V12     = 1,
    parameter int CORE_ID_BASE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_enable,
    input  logic [3:0]           cfg_sample_shift,
    input  logic [N_CH-1:0]      ch_valid,
    input  logic [N_CH*16-1:0]   ch_tx_id,
    input  logic [N_CH*64-1:0]   ch_t_ingress,
    input  logic [N_CH*128-1:0]  ch_attr,
    sentinel_trace_mux_if.master trace,
    output logic [31:0]          seq_no,
    output logic [N_CH*32-1:0]   ch_drop_count,
    output logic [N_CH-1:0]      ch_overflow
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] REC_TX_EVENT = 8'h01;

    typedef struct packed {
        logic [7:0]   version;
        logic [7:0]   record_type;
        logic [15:0]  core_id;
        logic [31:0]  seq_no;
        logic [63:0]  t_ingress;
        logic [63:0]  t_egress;
        logic [63:0]  t_host;
        logic [15:0]  tx_id;
        logic [15:0]  flags;
        logic [31:0]  d_ingress;
        logic [31:0]  d_core;
        logic [31:0]  d_risk;
        logic [31:0]  d_egress;
        logic [95:0]  rsvd;
    } trace_record_v12_t;

    typedef struct packed {
        logic [15:0]  tx_id;
        logic [63:0]  t_ingress;
        logic [127:0] attr;
        logic [63:0]  t_egress;
    } hold_t;

    logic [63:0]              cyc_q;
    logic [31:0]              seq_q;
    logic [PW-1:0]            rr_q;
    logic [AW:0]              wr_q, rd_q;
    logic [N_CH-1:0]          hold_vld_q;
    hold_t                    hold_q [N_CH];
    logic [15:0]              sc_q [N_CH];
    logic [N_CH-1:0][31:0]    drop_q;
    logic [N_CH-1:0]          ovf_q;
    trace_record_v12_t        mem [FIFO_DEPTH];

    logic                     empty, full, pop, push, grant_vld;
    logic [PW-1:0]            grant;
    logic [15:0]              smask;
    logic [N_CH-1:0]          keep;
    trace_record_v12_t        rec;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && trace.trace_ready;
    assign push  = grant_vld && (!full || pop);
    assign smask = 16'((17'd1 << cfg_sample_shift) - 17'd1);

    // Two ascending passes: channels at/after rr_q first, then the wrapped-around ones.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!grant_vld && hold_vld_q[i] && (PW'(i) >= rr_q)) begin
                grant_vld = 1'b1;
                grant     = PW'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!grant_vld && hold_vld_q[i]) begin
                grant_vld = 1'b1;
                grant     = PW'(i);
            end
        end
    end

    always_comb begin
        keep = '0;
        for (int i = 0; i < N_CH; i++)
            keep[i] = cfg_enable && ch_valid[i] && ((sc_q[i] & smask) == 16'd0);
    end

    always_comb begin
        rec             = '0;
        rec.version     = (EMIT_V12 != 0) ? 8'h02 : 8'h01;
        rec.record_type = REC_TX_EVENT;
        rec.core_id     = 16'(CORE_ID_BASE) + 16'(grant);
        rec.seq_no      = seq_q;
        rec.t_ingress   = hold_q[grant].t_ingress;
        rec.t_egress    = hold_q[grant].t_egress;
        rec.t_host      = 64'd0;
        rec.tx_id       = hold_q[grant].tx_id;
        rec.flags       = 16'h0001;
        rec.d_ingress   = hold_q[grant].attr[127:96];
        rec.d_core      = hold_q[grant].attr[95:64];
        rec.d_risk      = hold_q[grant].attr[63:32];
        rec.d_egress    = hold_q[grant].attr[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= '0;
            seq_q      <= '0;
            rr_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            hold_vld_q <= '0;
            drop_q     <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hold_q[i] <= '0;
                sc_q[i]   <= '0;
            end
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (push) begin
                seq_q <= seq_q + 32'd1;
                wr_q  <= wr_q + 1'b1;
                rr_q  <= (grant == PW'(N_CH - 1)) ? '0 : grant + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_enable && ch_valid[i])
                    sc_q[i] <= sc_q[i] + 16'd1;
                // A hold vacated on this same edge can take the new event without a drop.
                if (keep[i]) begin
                    if (hold_vld_q[i] && !(push && grant == PW'(i))) begin
                        if (drop_q[i] != 32'hFFFF_FFFF)
                            drop_q[i] <= drop_q[i] + 32'd1;
                        ovf_q[i] <= 1'b1;
                    end else begin
                        hold_q[i]     <= '{tx_id:     ch_tx_id[16*i +: 16],
                                           t_ingress: ch_t_ingress[64*i +: 64],
                                           attr:      ch_attr[128*i +: 128],
                                           t_egress:  cyc_q};
                        hold_vld_q[i] <= 1'b1;
                    end
                end else if (push && grant == PW'(i)) begin
                    hold_vld_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_q[AW-1:0]] <= rec;
    end

    assign trace.trace_valid = !empty;
    assign trace.trace_data  = mem[rd_q[AW-1:0]];
    assign trace.trace_size  = (EMIT_V12 != 0) ? 7'd64 : 7'd48;
    assign seq_no            = seq_q;
    assign ch_drop_count     = drop_q;
    assign ch_overflow       = ovf_q;
endmodule

// File: tb/tb_sentinel_trace_mux.sv
// Directed bench for sentinel_trace_mux: latency, arbitration order, overflow, sampling, wraps, reset.
module tb_sentinel_trace_mux;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_enable = 1'b1;
    logic [3:0]     cfg_sample_shift = 4'd0;
    logic [3:0]     ch_valid = '0;
    logic [63:0]    ch_tx_id = '0;
    logic [255:0]   ch_t_ingress = '0;
    logic [511:0]   ch_attr = '0;
    logic [31:0]    seq_no;
    logic [127:0]   ch_drop_count;
    logic [3:0]     ch_overflow;
    int             n_chk = 0;
    int             n_err = 0;

    sentinel_trace_mux_if trc();

    sentinel_trace_mux dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_enable       (cfg_enable),
        .cfg_sample_shift (cfg_sample_shift),
        .ch_valid         (ch_valid),
        .ch_tx_id         (ch_tx_id),
        .ch_t_ingress     (ch_t_ingress),
        .ch_attr          (ch_attr),
        .trace            (trc),
        .seq_no           (seq_no),
        .ch_drop_count    (ch_drop_count),
        .ch_overflow      (ch_overflow)
    );

    always #5 clk = ~clk;

    // Record field positions, MSB first: version, type, core_id, seq, t_ingress, t_egress, t_host, tx_id, flags, d_*.
    localparam int L_VER = 504, L_TYPE = 496, L_CORE = 480, L_SEQ = 448, L_TI = 384;
    localparam int L_TE = 320, L_TH = 256, L_TX = 240, L_FL = 224, L_DI = 192, L_DE = 96;

    function automatic logic [63:0] fld(input int lsb, input int w);
        logic [511:0] t;
        t = trc.trace_data >> lsb;
        if (w >= 64) return t[63:0];
        return t[63:0] & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic set_tx(input int ch, input logic [15:0] v);
        ch_tx_id[ch*16 +: 16] = v;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ch_t_ingress[i*64 +: 64] = 64'h1000 + 64'(i);
            ch_attr[i*128 +: 128]    = {32'hA0 + 32'(i), 32'hB0 + 32'(i), 32'hC0 + 32'(i), 32'hD0 + 32'(i)};
        end
        trc.trace_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid", 64'(trc.trace_valid), 64'd0);
        chk("rst_seq", 64'(seq_no), 64'd0);
        chk("rst_drop", ch_drop_count[63:0] | ch_drop_count[127:64], 64'd0);
        chk("rst_ovf", 64'(ch_overflow), 64'd0);
        chk("trace_size", 64'(trc.trace_size), 64'd64);

        // T1: single event captured at cycle 10, visible after the following edge
        trc.trace_ready = 1'b1;
        repeat (10) tick();
        set_tx(0, 16'd5);
        ch_valid = 4'b0001;
        tick();
        ch_valid = 4'b0000;
        chk("t1_not_yet", 64'(trc.trace_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(trc.trace_valid), 64'd1);
        chk("t1_version", fld(L_VER, 8), 64'h02);
        chk("t1_type", fld(L_TYPE, 8), 64'h01);
        chk("t1_core", fld(L_CORE, 16), 64'd0);
        chk("t1_seq", fld(L_SEQ, 32), 64'd0);
        chk("t1_t_ingress", fld(L_TI, 64), 64'h1000);
        chk("t1_t_egress", fld(L_TE, 64), 64'd10);
        chk("t1_t_host", fld(L_TH, 64), 64'd0);
        chk("t1_tx", fld(L_TX, 16), 64'd5);
        chk("t1_flags", fld(L_FL, 16), 64'd1);
        chk("t1_d_ingress", fld(L_DI, 32), 64'hA0);
        chk("t1_d_egress", fld(L_DE, 32), 64'hD0);
        chk("t1_seq_no", 64'(seq_no), 64'd1);
        tick();
        chk("t1_drained", 64'(trc.trace_valid), 64'd0);

        // T2: all channels at once, one push per cycle in channel order
        do_reset();
        trc.trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_tx(i, 16'(100 + i));
        ch_valid = 4'b1111;
        tick();
        ch_valid = 4'b0000;
        chk("t2_seq_start", 64'(seq_no), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_seq_step", 64'(seq_no), 64'(k + 1));
        end
        trc.trace_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_core", fld(L_CORE, 16), 64'(k));
            chk("t2_seq", fld(L_SEQ, 32), 64'(k));
            chk("t2_tx", fld(L_TX, 16), 64'(100 + k));
            tick();
        end
        chk("t2_empty", 64'(trc.trace_valid), 64'd0);
        chk("t2_nodrop", ch_drop_count[63:0] | ch_drop_count[127:64], 64'd0);

        // T3: ch1 streams into a stalled FIFO: 16 queued, 1 staged, 23 drops
        do_reset();
        trc.trace_ready = 1'b0;
        ch_valid = 4'b0010;
        for (int k = 0; k < 40; k++) begin
            set_tx(1, 16'(k));
            tick();
        end
        ch_valid = 4'b0000;
        chk("t3_seq", 64'(seq_no), 64'd16);
        chk("t3_drop1", 64'(ch_drop_count[63:32]), 64'd23);
        chk("t3_drop0", 64'(ch_drop_count[31:0]), 64'd0);
        chk("t3_drop23", ch_drop_count[127:64], 64'd0);
        chk("t3_ovf", 64'(ch_overflow), 64'b0010);

        // T5b: drop counter saturation
        force dut.drop_q = {32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0};
        #1;
        release dut.drop_q;
        chk("t5_drop_preload", 64'(ch_drop_count[63:32]), 64'hFFFF_FFFE);
        set_tx(1, 16'd999);
        ch_valid = 4'b0010;
        repeat (3) tick();
        ch_valid = 4'b0000;
        chk("t5_drop_sat", 64'(ch_drop_count[63:32]), 64'hFFFF_FFFF);
        chk("t5_ovf", 64'(ch_overflow), 64'b0010);

        trc.trace_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            chk("t3_drain_tx", fld(L_TX, 16), 64'(k));
            chk("t3_drain_seq", fld(L_SEQ, 32), 64'(k));
            tick();
        end
        chk("t3_empty", 64'(trc.trace_valid), 64'd0);
        chk("t3_seq_end", 64'(seq_no), 64'd17);

        // T4: 1-in-4 sampling on ch2 keeps events 1 and 5
        do_reset();
        trc.trace_ready = 1'b0;
        cfg_sample_shift = 4'd2;
        ch_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            set_tx(2, 16'(k));
            tick();
        end
        ch_valid = 4'b0000;
        repeat (2) tick();
        chk("t4_seq", 64'(seq_no), 64'd2);
        chk("t4_nodrop", 64'(ch_drop_count[95:64]), 64'd0);
        chk("t4_ovf", 64'(ch_overflow), 64'd0);
        trc.trace_ready = 1'b1;
        chk("t4_tx_a", fld(L_TX, 16), 64'd0);
        chk("t4_core", fld(L_CORE, 16), 64'd2);
        tick();
        chk("t4_tx_b", fld(L_TX, 16), 64'd4);
        tick();
        chk("t4_empty", 64'(trc.trace_valid), 64'd0);
        cfg_sample_shift = 4'd0;

        // Disabled capture ignores events entirely
        cfg_enable = 1'b0;
        ch_valid = 4'b1000;
        repeat (3) tick();
        ch_valid = 4'b0000;
        tick();
        chk("dis_valid", 64'(trc.trace_valid), 64'd0);
        chk("dis_seq", 64'(seq_no), 64'd2);
        chk("dis_drop", 64'(ch_drop_count[127:96]), 64'd0);
        cfg_enable = 1'b1;

        // T5: sequence number wrap; rr_ptr sits at 3 so ch0 wins before ch1
        trc.trace_ready = 1'b0;
        force dut.seq_q = 32'hFFFF_FFFF;
        #1;
        release dut.seq_q;
        chk("t5_seq_preload", 64'(seq_no), 64'hFFFF_FFFF);
        set_tx(0, 16'd7);
        set_tx(1, 16'd8);
        ch_valid = 4'b0011;
        tick();
        ch_valid = 4'b0000;
        repeat (2) tick();
        chk("t5_seq_after", 64'(seq_no), 64'd1);
        trc.trace_ready = 1'b1;
        chk("t5_rec_seq_a", fld(L_SEQ, 32), 64'hFFFF_FFFF);
        chk("t5_rec_core_a", fld(L_CORE, 16), 64'd0);
        tick();
        chk("t5_rec_seq_b", fld(L_SEQ, 32), 64'd0);
        chk("t5_rec_core_b", fld(L_CORE, 16), 64'd1);
        tick();
        chk("t5_empty", 64'(trc.trace_valid), 64'd0);

        // T6: reset with 5 queued records and all holds occupied
        do_reset();
        trc.trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_tx(i, 16'(200 + i));
        ch_valid = 4'b1111;
        repeat (6) tick();
        ch_valid = 4'b0000;
        chk("t6_pre_seq", 64'(seq_no), 64'd5);
        chk("t6_pre_valid", 64'(trc.trace_valid), 64'd1);
        chk("t6_pre_ovf", 64'(ch_overflow), 64'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 64'(trc.trace_valid), 64'd0);
        chk("t6_seq", 64'(seq_no), 64'd0);
        chk("t6_drop", ch_drop_count[63:0] | ch_drop_count[127:64], 64'd0);
        chk("t6_ovf", 64'(ch_overflow), 64'd0);
        tick();
        set_tx(2, 16'd42);
        ch_valid = 4'b0100;
        chk("t6_holds_cleared", 64'(trc.trace_valid), 64'd0);
        tick();
        ch_valid = 4'b0000;
        tick();
        chk("t6_new_valid", 64'(trc.trace_valid), 64'd1);
        chk("t6_new_seq", fld(L_SEQ, 32), 64'd0);
        chk("t6_new_core", fld(L_CORE, 16), 64'd2);
        chk("t6_new_tx", fld(L_TX, 16), 64'd42);
        chk("t6_new_t_egress", fld(L_TE, 64), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
